// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex glyph table and index-width helper for the seg7 scanner
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seg7_scan_mux_if.sv
// seg7_scan_mux_if: producer-side value/strobe inputs and display pin outputs
interface seg7_scan_mux_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] num;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic                    blank;
  logic [6:0]              seg;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;
  modport master (output num, dp, load, blank, input seg, dp_out, an, frame_start);
  modport slave  (input num, dp, load, blank, output seg, dp_out, an, frame_start);
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: 4-bit nibble to active-low {g,f,e,d,c,b,a} glyph
module seg7_hex_decode import seg7_pkg::*; (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = GLYPH[nib];
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: double-buffered multiplexed hex display scanner with ghost gap and blank
// Define SEG7_LZB_EN to suppress leading-zero digits above digit 0.
module seg7_scan_mux import seg7_pkg::*; #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int GHOST_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  seg7_scan_mux_if.slave  bus
);
  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = idx_w(REFRESH_DIV);
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_num_q, pend_num_d, disp_num_q, disp_num_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [6:0]              seg_q, seg_d, glyph;
  logic                    dp_out_q, dp_out_d, frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d, sup;
  logic [3:0]              nib;
  logic                    tick, boundary, lit;
`ifdef SEG7_LZB_EN
  logic zero_hi;
  always_comb begin
    zero_hi = 1'b1;
    sup = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_hi = zero_hi & (disp_num_q[4*k +: 4] == 4'h0);
      sup[k] = zero_hi & ~disp_dp_q[k];
    end
  end
`else
  assign sup = '0;
`endif
  seg7_hex_decode u_dec (.nib(nib), .seg(glyph));
  always_comb begin
    tick          = cnt_q == CW'(REFRESH_DIV - 1);
    boundary      = tick && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d         = tick ? '0 : cnt_q + CW'(1);
    idx_d         = boundary ? '0 : tick ? idx_q + IW'(1) : idx_q;
    pend_num_d    = bus.load ? bus.num : pend_num_q;
    pend_dp_d     = bus.load ? bus.dp : pend_dp_q;
    pend_valid_d  = !boundary && (pend_valid_q || bus.load);
    // A load on the boundary cycle itself bypasses the pending buffer
    disp_num_d    = !boundary ? disp_num_q : bus.load ? bus.num : pend_valid_q ? pend_num_q : disp_num_q;
    disp_dp_d     = !boundary ? disp_dp_q : bus.load ? bus.dp : pend_valid_q ? pend_dp_q : disp_dp_q;
    nib           = disp_num_q[{idx_q, 2'b00} +: 4];
    lit           = !bus.blank && cnt_q >= CW'(GHOST_CYCLES) && !sup[idx_q];
    an_d          = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    seg_d         = glyph;
    dp_out_d      = ~disp_dp_q[idx_q];
    frame_start_d = cnt_q == '0 && idx_q == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_num_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      disp_num_q    <= '0;
      disp_dp_q     <= '0;
      seg_q         <= SEG_BLANK;
      dp_out_q      <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_num_q    <= pend_num_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      disp_num_q    <= disp_num_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign bus.seg         = seg_q;
  assign bus.dp_out      = dp_out_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;
endmodule
